lp_core_arbiter: RTL and testbench
==================================

# lp_core_arbiter

Successor to the core-side LP conflict monitor. It tracks each core's LP, timestamp and state (idle / running / waiting) through an explicit per-core state machine. It serialises cores that hold the same LP in timestamp order and forwards per-LP history counts. It also publishes a registered global minimum timestamp (GVT candidate). Dispatch and return use separate ports, so a queue-to-core event and a core-to-queue event can land in the same cycle. It sits between the event queue and the core array.

## Interface
- NUM_CORE, 4: number of cores; any value ≥2, not limited to powers of two.
- NUM_LP, 8: number of logical processes.
- TIME_WID, 16: timestamp width.
- NB_HIST_DEPTH, 4: history-count width.
- MSG_WID, 32: message width; must be ≥ TIME_WID+NB_LPID+NB_HIST_DEPTH.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- disp_vld  in  1  event dispatched from queue to core disp_core.
- disp_core  in  NB_COREID  destination core.
- disp_msg  in  MSG_WID  fields: time [TIME_WID-1:0], LP [TIME_WID +: NB_LPID].
- ret_vld  in  1  core ret_core finished and returns its history count.
- ret_core  in  NB_COREID  returning core.
- ret_msg  in  MSG_WID  history count in [MSG_WID-1 -: NB_HIST_DEPTH].
- stall  out  NUM_CORE  per-core stall; 1 exactly when the core is in WAIT.
- core_busy  out  NUM_CORE  core is in RUN or WAIT.
- core_hist_cnt  out  NUM_CORE*NB_HIST_DEPTH  history count handed to each core.
- gvt  out  TIME_WID  minimum timestamp over busy cores.
- gvt_vld  out  1  at least one core is busy.
- proto_err  out  1  sticky protocol-violation flag.

## Operation
- Per-core FSM states are IDLE, RUN and WAIT. Per-core registers hold time, LP and hist. A per-LP history table has NUM_LP entries.
- Return (ret_vld, core in RUN):
  - The core moves RUN→IDLE.
  - lp_hist[core LP] is set to the returned hist.
  - Among WAIT cores with the same LP, the one with the minimum time moves to RUN; on equal times the lowest core id wins.
  - The promoted core's core_hist_cnt is set to the returned hist.
- Dispatch (disp_vld, core in IDLE):
  - Time and LP are latched.
  - core_hist_cnt is set to lp_hist[LP].
  - If any other busy core holds the same LP, the core moves to WAIT. Otherwise it moves to RUN.
- Simultaneous dispatch and return: the return is evaluated first, and the dispatch sees the post-return state.
  - If the dispatch LP equals the returning LP:
    - If a waiter is promoted, the new core goes to WAIT.
    - If no waiter is promoted, the new core goes to RUN.
    - Either way the dispatch hist bypasses to the returned value.
  - disp_core == ret_core is legal: the core goes RUN→IDLE→new state within the same cycle.
- Violations set proto_err and the offending operation is ignored:
  - dispatch to a non-IDLE core (after the same-cycle return is applied);
  - return from a core that is not in RUN.
- proto_err clears only on reset.

## Timing
- Reset (async) clears the following immediately: all FSMs to IDLE, stall=0, core_busy=0, core_hist_cnt=0, lp_hist=0, gvt=0, gvt_vld=0, proto_err=0.
- The FSM state, stall, core_busy and core_hist_cnt all update at the edge that samples the valid signal. That gives 1-cycle latency from request to output.
- Promotion clears the waiter's stall at that same edge.
- gvt/gvt_vld come from a registered min-reduction over the state registers. They lag the state by one cycle (2 edges after the request).
- When no core is busy, gvt holds its last value and gvt_vld=0.
- Timestamps compare as unsigned; there is no wrap handling.

## Structure
- Package lp_core_arb_pkg holds:
  - the state enum {IDLE, RUN, WAIT};
  - message field offset constants;
  - NB_COREID = max(1, $clog2(NUM_CORE)) and NB_LPID = max(1, $clog2(NUM_LP)).
- Sub-module masked_argmin_tree is parametrised on width and count:
  - it pads to a power of two with invalid leaves;
  - on ties it picks the lowest index;
  - it outputs min, idx and vld.
  - It is instantiated twice: once for waiter promotion and once for GVT.
- Expected size is about 250 lines of RTL.

## Test plan
All scenarios use NUM_CORE=4, NUM_LP=8, TIME_WID=16.
- Dispatch LP3 t=10 to c0, then LP3 t=7 to c1 → c0 RUN; c1 WAIT with stall=4'b0010; gvt=7 two cycles later.
- Return from c0 with hist=5 → c1 RUN, stall=0, core_hist_cnt[c1]=5, lp_hist[3]=5; next dispatch of LP3 to c2 (c1 still running) → c2 WAIT with core_hist_cnt[c2]=5.
- Waiters c1 and c2 on LP2, both t=20 → return of the owner promotes c1 (lower id), c2 stays stalled.
- Same-cycle return from c0 (LP1, hist=9, no waiters) and dispatch LP1 to c3 → c3 RUN, core_hist_cnt[c3]=9; then same-cycle return from c0 and dispatch to c0 → c0 RUN with the new LP, no proto_err.
- Dispatch to a busy core, or return from an IDLE core → proto_err=1 sticky, state unchanged.
- Assert reset mid-operation with 3 cores busy → all outputs zero immediately, no clock edge needed.

Source files
------------

// File: rtl/lp_core_arb_pkg.sv
// Shared types and helpers for the LP core arbiter: per-core state encoding,
// message field offsets and identifier width helpers.
package lp_core_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } core_state_t;

    localparam int MSG_TIME_LSB = 0;

    // Width of an identifier able to address n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int msg_lp_lsb(input int time_wid);
        return MSG_TIME_LSB + time_wid;
    endfunction

    function automatic int msg_hist_msb(input int msg_wid);
        return msg_wid - 1;
    endfunction

endpackage

// File: rtl/masked_argmin_tree.sv
// Combinational masked arg-min over COUNT values; invalid entries are skipped,
// ties resolve to the lowest index.
module masked_argmin_tree
    import lp_core_arb_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int COUNT   = 4,
    parameter int IDX_WID = id_width(COUNT)
) (
    input  logic [COUNT*WIDTH-1:0] i_val,
    input  logic [COUNT-1:0]       i_vld,
    output logic [WIDTH-1:0]       o_min,
    output logic [IDX_WID-1:0]     o_idx,
    output logic                   o_vld
);

    localparam int LEAVES = 1 << $clog2(COUNT);

    logic [WIDTH-1:0]   w_node_min [2*LEAVES];
    logic [IDX_WID-1:0] w_node_idx [2*LEAVES];
    logic               w_node_vld [2*LEAVES];

    // Heap-ordered tree: leaves at LEAVES..2*LEAVES-1, padded leaves stay invalid.
    always_comb begin
        for (int k = 0; k < 2*LEAVES; k++) begin
            w_node_min[k] = '0;
            w_node_idx[k] = '0;
            w_node_vld[k] = 1'b0;
        end
        for (int i = 0; i < COUNT; i++) begin
            w_node_min[LEAVES+i] = i_val[i*WIDTH +: WIDTH];
            w_node_idx[LEAVES+i] = IDX_WID'(i);
            w_node_vld[LEAVES+i] = i_vld[i];
        end
        for (int k = LEAVES - 1; k >= 1; k--) begin
            if (w_node_vld[2*k] && (!w_node_vld[2*k+1] || (w_node_min[2*k] <= w_node_min[2*k+1]))) begin
                w_node_min[k] = w_node_min[2*k];
                w_node_idx[k] = w_node_idx[2*k];
            end else begin
                w_node_min[k] = w_node_min[2*k+1];
                w_node_idx[k] = w_node_idx[2*k+1];
            end
            w_node_vld[k] = w_node_vld[2*k] | w_node_vld[2*k+1];
        end
        o_min = w_node_min[1];
        o_idx = w_node_idx[1];
        o_vld = w_node_vld[1];
    end

endmodule

// File: rtl/lp_core_arbiter.sv
// Tracks per-core LP/timestamp/state, serialises cores sharing an LP in
// timestamp order, forwards per-LP history counts and publishes a GVT candidate.
module lp_core_arbiter
    import lp_core_arb_pkg::*;
#(
    parameter int NUM_CORE      = 4,
    parameter int NUM_LP        = 8,
    parameter int TIME_WID      = 16,
    parameter int NB_HIST_DEPTH = 4,
    parameter int MSG_WID       = 32,
    parameter int NB_COREID     = id_width(NUM_CORE),
    parameter int NB_LPID       = id_width(NUM_LP)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              disp_vld,
    input  logic [NB_COREID-1:0]              disp_core,
    input  logic [MSG_WID-1:0]                disp_msg,
    input  logic                              ret_vld,
    input  logic [NB_COREID-1:0]              ret_core,
    input  logic [MSG_WID-1:0]                ret_msg,
    output logic [NUM_CORE-1:0]               stall,
    output logic [NUM_CORE-1:0]               core_busy,
    output logic [NUM_CORE*NB_HIST_DEPTH-1:0] core_hist_cnt,
    output logic [TIME_WID-1:0]               gvt,
    output logic                              gvt_vld,
    output logic                              proto_err
);

    core_state_t              r_state   [NUM_CORE];
    logic [TIME_WID-1:0]      r_time    [NUM_CORE];
    logic [NB_LPID-1:0]       r_lp      [NUM_CORE];
    logic [NB_HIST_DEPTH-1:0] r_hist    [NUM_CORE];
    logic [NB_HIST_DEPTH-1:0] r_lp_hist [NUM_LP];
    logic [TIME_WID-1:0]      r_gvt;
    logic                     r_gvt_vld;
    logic                     r_proto_err;

    logic [TIME_WID-1:0]      w_disp_time;
    logic [NB_LPID-1:0]       w_disp_lp;
    logic [NB_HIST_DEPTH-1:0] w_disp_hist;
    logic [NB_HIST_DEPTH-1:0] w_ret_hist;
    logic [NB_LPID-1:0]       w_ret_lp;
    logic                     w_ret_ok;
    logic                     w_disp_ok;
    logic                     w_disp_conflict;
    logic                     w_msg_unused;
    core_state_t              w_next_state [NUM_CORE];

    logic [NUM_CORE*TIME_WID-1:0] w_time_flat;
    logic [NUM_CORE-1:0]          w_wait_match;
    logic [NUM_CORE-1:0]          w_busy;
    logic [TIME_WID-1:0]          w_prom_min_unused;
    logic [NB_COREID-1:0]         w_prom_idx;
    logic                         w_prom_vld;
    logic [TIME_WID-1:0]          w_gvt_min;
    logic [NB_COREID-1:0]         w_gvt_idx_unused;
    logic                         w_gvt_vld;

    assign w_disp_time  = disp_msg[MSG_TIME_LSB +: TIME_WID];
    assign w_disp_lp    = disp_msg[msg_lp_lsb(TIME_WID) +: NB_LPID];
    assign w_ret_hist   = ret_msg[msg_hist_msb(MSG_WID) -: NB_HIST_DEPTH];
    assign w_ret_lp     = r_lp[ret_core];
    assign w_ret_ok     = ret_vld && (32'(ret_core) < NUM_CORE) && (r_state[ret_core] == RUN);
    assign w_msg_unused = ^{disp_msg, ret_msg};

    // A dispatch to the returning LP sees the freshly returned count, not the stale table entry.
    assign w_disp_hist = (w_ret_ok && (w_ret_lp == w_disp_lp)) ? w_ret_hist :
                         ((32'(w_disp_lp) < NUM_LP) ? r_lp_hist[w_disp_lp] : '0);

    always_comb begin
        for (int i = 0; i < NUM_CORE; i++) begin
            w_time_flat[i*TIME_WID +: TIME_WID] = r_time[i];
            w_busy[i]       = (r_state[i] != IDLE);
            w_wait_match[i] = w_ret_ok && (r_state[i] == WAIT) && (r_lp[i] == w_ret_lp);
        end
    end

    masked_argmin_tree #(.WIDTH(TIME_WID), .COUNT(NUM_CORE), .IDX_WID(NB_COREID)) u_prom_tree (
        .i_val (w_time_flat),
        .i_vld (w_wait_match),
        .o_min (w_prom_min_unused),
        .o_idx (w_prom_idx),
        .o_vld (w_prom_vld)
    );

    masked_argmin_tree #(.WIDTH(TIME_WID), .COUNT(NUM_CORE), .IDX_WID(NB_COREID)) u_gvt_tree (
        .i_val (w_time_flat),
        .i_vld (w_busy),
        .o_min (w_gvt_min),
        .o_idx (w_gvt_idx_unused),
        .o_vld (w_gvt_vld)
    );

    // Apply the return (and any promotion) first; the dispatch then judges the post-return state.
    always_comb begin
        for (int i = 0; i < NUM_CORE; i++) begin
            w_next_state[i] = r_state[i];
        end
        if (w_ret_ok) begin
            w_next_state[ret_core] = IDLE;
        end
        if (w_prom_vld) begin
            w_next_state[w_prom_idx] = RUN;
        end
        w_disp_ok       = disp_vld && (32'(disp_core) < NUM_CORE) && (w_next_state[disp_core] == IDLE);
        w_disp_conflict = 1'b0;
        for (int j = 0; j < NUM_CORE; j++) begin
            if ((NB_COREID'(j) != disp_core) && (w_next_state[j] != IDLE) && (r_lp[j] == w_disp_lp)) begin
                w_disp_conflict = 1'b1;
            end
        end
        if (w_disp_ok) begin
            w_next_state[disp_core] = w_disp_conflict ? WAIT : RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CORE; i++) begin
                r_state[i] <= IDLE;
                r_time[i]  <= '0;
                r_lp[i]    <= '0;
                r_hist[i]  <= '0;
            end
            for (int l = 0; l < NUM_LP; l++) begin
                r_lp_hist[l] <= '0;
            end
            r_gvt       <= '0;
            r_gvt_vld   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CORE; i++) begin
                r_state[i] <= w_next_state[i];
            end
            if (w_prom_vld) begin
                r_hist[w_prom_idx] <= w_ret_hist;
            end
            if (w_disp_ok) begin
                r_time[disp_core] <= w_disp_time;
                r_lp[disp_core]   <= w_disp_lp;
                r_hist[disp_core] <= w_disp_hist;
            end
            if (w_ret_ok && (32'(w_ret_lp) < NUM_LP)) begin
                r_lp_hist[w_ret_lp] <= w_ret_hist;
            end
            r_gvt_vld <= w_gvt_vld;
            if (w_gvt_vld) begin
                r_gvt <= w_gvt_min;
            end
            if ((disp_vld && !w_disp_ok) || (ret_vld && !w_ret_ok)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CORE; i++) begin
            stall[i]     = (r_state[i] == WAIT);
            core_busy[i] = (r_state[i] != IDLE);
            core_hist_cnt[i*NB_HIST_DEPTH +: NB_HIST_DEPTH] = r_hist[i];
        end
    end

    assign gvt       = r_gvt;
    assign gvt_vld   = r_gvt_vld;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_lp_core_arbiter.sv
// Directed and randomized bench for lp_core_arbiter, checked against a
// rule-level model of cores, LP ownership and history counts.
module tb_lp_core_arbiter;

    logic        clk;
    logic        reset;
    logic        disp_vld;
    logic [1:0]  disp_core;
    logic [31:0] disp_msg;
    logic        ret_vld;
    logic [1:0]  ret_core;
    logic [31:0] ret_msg;
    logic [3:0]  stall;
    logic [3:0]  core_busy;
    logic [15:0] core_hist_cnt;
    logic [15:0] gvt;
    logic        gvt_vld;
    logic        proto_err;

    int n_vec = 0;
    int n_err = 0;

    // Model: 0 = idle, 1 = running, 2 = waiting.
    int m_st   [4];
    int m_time [4];
    int m_lp   [4];
    int m_hist [4];
    int m_lph  [8];
    int m_gvt;
    int m_gvt_vld;
    int m_err;

    lp_core_arbiter #(
        .NUM_CORE(4), .NUM_LP(8), .TIME_WID(16), .NB_HIST_DEPTH(4), .MSG_WID(32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .disp_vld      (disp_vld),
        .disp_core     (disp_core),
        .disp_msg      (disp_msg),
        .ret_vld       (ret_vld),
        .ret_core      (ret_core),
        .ret_msg       (ret_msg),
        .stall         (stall),
        .core_busy     (core_busy),
        .core_hist_cnt (core_hist_cnt),
        .gvt           (gvt),
        .gvt_vld       (gvt_vld),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            m_st[i] = 0; m_time[i] = 0; m_lp[i] = 0; m_hist[i] = 0;
        end
        for (int l = 0; l < 8; l++) m_lph[l] = 0;
        m_gvt = 0; m_gvt_vld = 0; m_err = 0;
    endtask

    task automatic modelStep(input int dv, input int dc, input int dt, input int dl,
                             input int rv, input int rc, input int rh);
        int mn;
        int best;
        int conflict;
        // The published minimum reflects the occupancy before this edge.
        mn = -1;
        for (int i = 0; i < 4; i++)
            if (m_st[i] != 0 && (mn < 0 || m_time[i] < mn)) mn = m_time[i];
        if (mn >= 0) begin m_gvt = mn; m_gvt_vld = 1; end
        else m_gvt_vld = 0;
        if (rv != 0) begin
            if (m_st[rc] != 1) m_err = 1;
            else begin
                m_st[rc] = 0;
                m_lph[m_lp[rc]] = rh;
                best = -1;
                for (int i = 0; i < 4; i++)
                    if (m_st[i] == 2 && m_lp[i] == m_lp[rc] && (best < 0 || m_time[i] < m_time[best]))
                        best = i;
                if (best >= 0) begin m_st[best] = 1; m_hist[best] = rh; end
            end
        end
        if (dv != 0) begin
            if (m_st[dc] != 0) m_err = 1;
            else begin
                conflict = 0;
                for (int j = 0; j < 4; j++)
                    if (j != dc && m_st[j] != 0 && m_lp[j] == dl) conflict = 1;
                m_time[dc] = dt; m_lp[dc] = dl; m_hist[dc] = m_lph[dl];
                m_st[dc] = conflict ? 2 : 1;
            end
        end
    endtask

    task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0]  es;
        logic [3:0]  eb;
        logic [15:0] eh;
        for (int i = 0; i < 4; i++) begin
            es[i] = (m_st[i] == 2);
            eb[i] = (m_st[i] != 0);
            eh[i*4 +: 4] = 4'(m_hist[i]);
        end
        compareValue({tag, ".stall"}, 32'(stall), 32'(es));
        compareValue({tag, ".busy"}, 32'(core_busy), 32'(eb));
        compareValue({tag, ".hist"}, 32'(core_hist_cnt), 32'(eh));
        compareValue({tag, ".gvt"}, 32'(gvt), 32'(16'(m_gvt)));
        compareValue({tag, ".gvt_vld"}, 32'(gvt_vld), 32'(m_gvt_vld));
        compareValue({tag, ".proto_err"}, 32'(proto_err), 32'(m_err));
    endtask

    task automatic applyStimulus(input string tag,
                                 input logic dv, input logic [1:0] dc, input logic [15:0] dt, input logic [2:0] dl,
                                 input logic rv, input logic [1:0] rc, input logic [3:0] rh);
        disp_vld  = dv;
        disp_core = dc;
        disp_msg  = {13'd0, dl, dt};
        ret_vld   = rv;
        ret_core  = rc;
        ret_msg   = {rh, 28'd0};
        modelStep(int'(dv), int'(dc), int'(dt), int'(dl), int'(rv), int'(rc), int'(rh));
        @(posedge clk);
        #1;
        disp_vld = 1'b0;
        ret_vld  = 1'b0;
        checkOutput(tag);
    endtask

    function automatic logic [1:0] pickCore(input int want, input int allow_bad);
        int c[$];
        for (int i = 0; i < 4; i++) if (m_st[i] == want) c.push_back(i);
        if (c.size() == 0 || (allow_bad != 0 && $urandom_range(0, 24) == 0))
            return 2'($urandom_range(0, 3));
        return 2'(c[$urandom_range(0, c.size() - 1)]);
    endfunction

    task automatic randomPhase(input int cycles, input int allow_bad);
        logic       dv, rv;
        logic [1:0] dc, rc;
        for (int n = 0; n < cycles; n++) begin
            rv = ($urandom_range(0, 1) == 1);
            rc = pickCore(1, allow_bad);
            if (rv && allow_bad == 0 && m_st[rc] != 1) rv = 1'b0;
            dv = ($urandom_range(0, 1) == 1);
            dc = (rv && $urandom_range(0, 5) == 0) ? rc : pickCore(0, allow_bad);
            if (dv && allow_bad == 0 && m_st[dc] != 0 && !(rv && dc == rc)) dv = 1'b0;
            applyStimulus("rand", dv, dc, 16'($urandom_range(0, 31)), 3'($urandom_range(0, 3)),
                          rv, rc, 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        disp_vld = 1'b0; disp_core = '0; disp_msg = '0;
        ret_vld = 1'b0; ret_core = '0; ret_msg = '0;
        modelReset();
        #1;
        checkOutput("reset");
        #11;
        reset = 1'b0;

        // Two cores on LP3: the later dispatch waits even with an earlier timestamp.
        applyStimulus("lp3_c0", 1, 2'd0, 16'd10, 3'd3, 0, 2'd0, 4'd0);
        applyStimulus("lp3_c1", 1, 2'd1, 16'd7, 3'd3, 0, 2'd0, 4'd0);
        compareValue("lp3_stall", 32'(stall), 32'h2);
        applyStimulus("lp3_gvt", 0, 2'd0, 16'd0, 3'd0, 0, 2'd0, 4'd0);
        compareValue("lp3_gvt7", 32'(gvt), 32'd7);

        applyStimulus("lp3_ret", 0, 2'd0, 16'd0, 3'd0, 1, 2'd0, 4'd5);
        compareValue("promote_c1_hist", 32'(core_hist_cnt[7:4]), 32'd5);
        compareValue("promote_c1_stall", 32'(stall), 32'h0);
        applyStimulus("lp3_c2", 1, 2'd2, 16'd12, 3'd3, 0, 2'd0, 4'd0);
        compareValue("c2_hist_from_table", 32'(core_hist_cnt[11:8]), 32'd5);
        applyStimulus("lp3_ret_c1", 0, 2'd0, 16'd0, 3'd0, 1, 2'd1, 4'd6);
        applyStimulus("lp3_ret_c2", 0, 2'd0, 16'd0, 3'd0, 1, 2'd2, 4'd7);

        // Equal-time waiters on LP2: lowest core id is promoted.
        applyStimulus("lp2_c0", 1, 2'd0, 16'd15, 3'd2, 0, 2'd0, 4'd0);
        applyStimulus("lp2_c1", 1, 2'd1, 16'd20, 3'd2, 0, 2'd0, 4'd0);
        applyStimulus("lp2_c2", 1, 2'd2, 16'd20, 3'd2, 0, 2'd0, 4'd0);
        applyStimulus("lp2_ret", 0, 2'd0, 16'd0, 3'd0, 1, 2'd0, 4'd3);
        compareValue("tie_stall", 32'(stall), 32'h4);
        applyStimulus("lp2_ret_c1", 0, 2'd0, 16'd0, 3'd0, 1, 2'd1, 4'd4);
        applyStimulus("lp2_ret_c2", 0, 2'd0, 16'd0, 3'd0, 1, 2'd2, 4'd1);

        // Same-cycle return and dispatch, including onto the returning core.
        applyStimulus("lp1_c0", 1, 2'd0, 16'd30, 3'd1, 0, 2'd0, 4'd0);
        applyStimulus("bypass", 1, 2'd3, 16'd31, 3'd1, 1, 2'd0, 4'd9);
        compareValue("bypass_c3_hist", 32'(core_hist_cnt[15:12]), 32'd9);
        applyStimulus("lp4_c0", 1, 2'd0, 16'd40, 3'd4, 0, 2'd0, 4'd0);
        applyStimulus("self_redisp", 1, 2'd0, 16'd41, 3'd5, 1, 2'd0, 4'd2);
        compareValue("self_busy", 32'(core_busy), 32'h9);
        compareValue("self_no_err", 32'(proto_err), 32'd0);

        // Protocol violations are ignored but stick.
        applyStimulus("bad_disp", 1, 2'd3, 16'd50, 3'd6, 0, 2'd0, 4'd0);
        compareValue("bad_disp_err", 32'(proto_err), 32'd1);
        applyStimulus("bad_ret", 0, 2'd0, 16'd0, 3'd0, 1, 2'd1, 4'd8);

        // Asynchronous reset with three cores busy.
        applyStimulus("lp6_c1", 1, 2'd1, 16'd50, 3'd6, 0, 2'd0, 4'd0);
        compareValue("three_busy", 32'(core_busy), 32'hB);
        #1;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("async_reset");
        #4;
        reset = 1'b0;

        randomPhase(250, 0);
        randomPhase(200, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
